// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions for the peripheral-side SRAM responder.
// Holds the Channel A / Channel D opcode encodings, the largest supported
// transfer size and an alignment helper.
package tlul_pkg;

   localparam logic [2:0] PUT_FULL        = 3'd0;
   localparam logic [2:0] PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] GET             = 3'd4;

   localparam logic [2:0] ACCESS_ACK      = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

   localparam int         MAX_SIZE        = 2;

   // Halfword accesses need addr[0]=0; word accesses need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [2:0] size,
                                          input logic [1:0] addr_lo);
      return ((size == 3'd1) && addr_lo[0]) ||
             ((size == 3'd2) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/tlul_sram_bytemask_mem.sv
// Word array with per-byte write enables and an asynchronous read port.
// Ports:
//   clk_i   - clock
//   addr_i  - word index, shared by the read and the write
//   we_i    - byte-lane write enables (lane i covers bits 8i+7:8i)
//   wdata_i - write data
//   rdata_o - combinational read of the word at addr_i
// Contents are not reset.
module tlul_sram_bytemask_mem #(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk_i,
   input  logic [IDX_W-1:0] addr_i,
   input  logic [3:0]       we_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/tlul_sram_slave.sv
// TL-UL SRAM responder on the peripheral bus. Decodes Channel A requests,
// checks them, performs the byte-masked write or the word read against the
// internal array and returns the result through a single registered
// Channel D response. A new request can be accepted every cycle while the
// master keeps d_ready_i high.
// Ports:
//   clk_i, reset_i       - clock, synchronous active-high reset
//   a_*_i / a_ready_o    - Channel A request and ready
//   d_*_o / d_ready_i    - Channel D response and ready
module tlul_sram_slave
   import tlul_pkg::*;
#(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
   parameter int                    SIZE_WIDTH   = 3,
   parameter int                    OPCODE_WIDTH = 3,
   parameter int                    PARAM_WIDTH  = 3,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h4000_0000,
   parameter int                    DEPTH_WORDS  = 256,
   parameter logic                  SINK_ID      = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    a_valid_i,
   output logic                    a_ready_o,
   input  logic [OPCODE_WIDTH-1:0] a_opcode_i,
   input  logic [PARAM_WIDTH-1:0]  a_param_i,
   input  logic [SIZE_WIDTH-1:0]   a_size_i,
   input  logic                    a_source_i,
   input  logic [ADDR_WIDTH-1:0]   a_address_i,
   input  logic [MASK_WIDTH-1:0]   a_mask_i,
   input  logic [DATA_WIDTH-1:0]   a_data_i,
   output logic                    d_valid_o,
   input  logic                    d_ready_i,
   output logic [OPCODE_WIDTH-1:0] d_opcode_o,
   output logic [PARAM_WIDTH-1:0]  d_param_o,
   output logic [SIZE_WIDTH-1:0]   d_size_o,
   output logic                    d_source_o,
   output logic                    d_sink_o,
   output logic [DATA_WIDTH-1:0]   d_data_o,
   output logic                    d_error_o
);

   localparam int                    IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * DEPTH_WORDS);

   logic                    d_valid_q,  d_valid_d;
   logic [OPCODE_WIDTH-1:0] d_opcode_q, d_opcode_d;
   logic [SIZE_WIDTH-1:0]   d_size_q,   d_size_d;
   logic                    d_source_q, d_source_d;
   logic [DATA_WIDTH-1:0]   d_data_q,   d_data_d;
   logic                    d_error_q,  d_error_d;

   logic                    accept;
   logic                    is_get, is_put, req_err, in_range;
   logic [ADDR_WIDTH-1:0]   offset;
   logic [IDX_W-1:0]        idx;
   logic [MASK_WIDTH-1:0]   mem_we;
   logic [DATA_WIDTH-1:0]   mem_rdata;
   logic                    unused_bits;

   assign a_ready_o = !reset_i && (!d_valid_q || d_ready_i);
   assign accept    = a_valid_i && a_ready_o;

   assign is_get   = (a_opcode_i == OPCODE_WIDTH'(GET));
   assign is_put   = (a_opcode_i == OPCODE_WIDTH'(PUT_FULL)) ||
                     (a_opcode_i == OPCODE_WIDTH'(PUT_PARTIAL));
   assign offset   = a_address_i - BASE_ADDR;
   assign in_range = (a_address_i >= BASE_ADDR) && (offset < SPAN);
   assign idx      = offset[IDX_W+1:2];

   // A full-word PutFullData must enable every lane.
   assign req_err = !(is_get || is_put) ||
                    (a_size_i > SIZE_WIDTH'(MAX_SIZE)) ||
                    is_misaligned(3'(a_size_i), a_address_i[1:0]) ||
                    !in_range ||
                    ((a_opcode_i == OPCODE_WIDTH'(PUT_FULL)) &&
                     (a_size_i == SIZE_WIDTH'(2)) &&
                     (a_mask_i != {MASK_WIDTH{1'b1}}));

   assign mem_we = (accept && is_put && !req_err) ? a_mask_i : '0;

   tlul_sram_bytemask_mem #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_mem (
      .clk_i   (clk_i),
      .addr_i  (idx),
      .we_i    (mem_we),
      .wdata_i (a_data_i),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      d_valid_d  = d_valid_q;
      d_opcode_d = d_opcode_q;
      d_size_d   = d_size_q;
      d_source_d = d_source_q;
      d_data_d   = d_data_q;
      d_error_d  = d_error_q;
      if (accept) begin
         // Accept and D-fire in the same cycle reload without a bubble.
         d_valid_d  = 1'b1;
         d_opcode_d = is_get ? OPCODE_WIDTH'(ACCESS_ACK_DATA)
                             : OPCODE_WIDTH'(ACCESS_ACK);
         d_size_d   = a_size_i;
         d_source_d = a_source_i;
         d_data_d   = (is_get && !req_err) ? mem_rdata : '0;
         d_error_d  = req_err;
      end else if (d_valid_q && d_ready_i) begin
         d_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         d_valid_q  <= 1'b0;
         d_opcode_q <= '0;
         d_size_q   <= '0;
         d_source_q <= 1'b0;
         d_data_q   <= '0;
         d_error_q  <= 1'b0;
      end else begin
         d_valid_q  <= d_valid_d;
         d_opcode_q <= d_opcode_d;
         d_size_q   <= d_size_d;
         d_source_q <= d_source_d;
         d_data_q   <= d_data_d;
         d_error_q  <= d_error_d;
      end
   end

   assign d_valid_o  = d_valid_q;
   assign d_opcode_o = d_opcode_q;
   assign d_param_o  = '0;
   assign d_size_o   = d_size_q;
   assign d_source_o = d_source_q;
   assign d_sink_o   = SINK_ID;
   assign d_data_o   = d_data_q;
   assign d_error_o  = d_error_q;

   // a_param is ignored; offset bits outside the word index are covered by
   // the range and alignment checks.
   assign unused_bits = ^{a_param_i, offset[1:0], offset[ADDR_WIDTH-1:IDX_W+2]};

endmodule
